// File: rtl/sobel_stream.sv
// sobel_stream
// Streaming 3x3 Sobel edge detector. Each frame is a 4-byte header
// (W lo, W hi, H lo, H hi) followed by W*H row-major 8-bit pixels. The
// block emits (W-2)*(H-2) edge pixels through a small output FIFO.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   data_in/valid_in  header or pixel byte in, ready_in = accept this cycle
//   mode              0 |Gx|+|Gy|, 1 |Gx|, 2 |Gy|, 3 binary threshold
//   threshold         compare value for mode 3
//   data_out/valid_out  edge pixel out, consumed when ready_out is high
//   frame_done        one-cycle pulse after the last output of a frame
//   hdr_error         sticky flag for a rejected header
module sobel_stream #(
   parameter int MAX_WIDTH  = 1024,
   parameter int OUT_SHIFT  = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        valid_in,
   output logic        ready_in,
   input  logic [1:0]  mode,
   input  logic [10:0] threshold,
   output logic [7:0]  data_out,
   output logic        valid_out,
   input  logic        ready_out,
   output logic        frame_done,
   output logic        hdr_error
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [16:0] MAXW_L      = 17'(MAX_WIDTH);
   localparam logic [PW:0] FIFO_LIMIT  = (PW+1)'(FIFO_DEPTH - 4);

   typedef enum logic [1:0] {HDR, PIX, SKIP, DRAIN} state_t;

   state_t        state;
   logic [1:0]    hdr_cnt;
   logic [15:0]   width, height, col, row;
   logic [1:0]    mode_q;
   logic [10:0]   thr_q;

   logic [7:0]    lb0 [0:MAX_WIDTH-1];
   logic [7:0]    lb1 [0:MAX_WIDTH-1];
   logic [7:0]    win [0:2][0:2];
   logic [AW-1:0] lb_addr;

   logic          s0_valid, s1_valid, s2_valid;
   logic [11:0]   abs_gx, abs_gy;
   logic [7:0]    s2_data;

   logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   fifo_count;
   logic          push, pop;

   logic          accept, last_col, last_row;
   logic [15:0]   hdr_h;
   logic          hdr_ok, hdr_empty;

   logic [11:0]   gx_p, gx_n, gy_p, gy_n, abs_gx_c, abs_gy_c;
   logic [11:0]   sum, sel, shifted;
   logic [7:0]    value_c;

   assign accept    = valid_in && ready_in;
   assign last_col  = (col == width - 16'd1);
   assign last_row  = (row == height - 16'd1);
   assign lb_addr   = col[AW-1:0];
   assign hdr_h     = {data_in, height[7:0]};
   assign hdr_ok    = (width >= 16'd3) && (hdr_h >= 16'd3) && ({1'b0, width} <= MAXW_L);
   assign hdr_empty = (width == 16'd0) || (hdr_h == 16'd0);
   assign push      = s2_valid;
   assign pop       = (fifo_count != '0) && (!valid_out || ready_out);

   // Input is throttled in PIX so that the three results already in
   // flight plus the one being accepted always find room in the FIFO.
   always_comb begin
      ready_in = 1'b0;
      case (state)
         HDR, SKIP: ready_in = 1'b1;
         PIX:       ready_in = (fifo_count <= FIFO_LIMIT);
         default:   ready_in = 1'b0;
      endcase
   end

   // Frame control: header capture, row/column scanning for both real
   // and skipped frames, and the drain handshake that ends a frame.
   // A rejected header with a zero dimension has nothing to skip.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HDR;
         hdr_cnt    <= 2'd0;
         width      <= 16'd0;
         height     <= 16'd0;
         col        <= 16'd0;
         row        <= 16'd0;
         mode_q     <= 2'd0;
         thr_q      <= 11'd0;
         hdr_error  <= 1'b0;
         frame_done <= 1'b0;
         s0_valid   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         s0_valid   <= 1'b0;
         case (state)
            HDR: if (accept) begin
               hdr_cnt <= hdr_cnt + 2'd1;
               case (hdr_cnt)
                  2'd0: width[7:0]  <= data_in;
                  2'd1: width[15:8] <= data_in;
                  2'd2: height[7:0] <= data_in;
                  default: begin
                     height[15:8] <= data_in;
                     mode_q       <= mode;
                     thr_q        <= threshold;
                     col          <= 16'd0;
                     row          <= 16'd0;
                     if (hdr_ok) begin
                        hdr_error <= 1'b0;
                        state     <= PIX;
                     end else begin
                        hdr_error <= 1'b1;
                        state     <= hdr_empty ? HDR : SKIP;
                     end
                  end
               endcase
            end
            PIX, SKIP: if (accept) begin
               if (state == PIX)
                  s0_valid <= (row >= 16'd2) && (col >= 16'd2);
               if (last_col) begin
                  col <= 16'd0;
                  row <= row + 16'd1;
               end else begin
                  col <= col + 16'd1;
               end
               if (last_col && last_row)
                  state <= (state == PIX) ? DRAIN : HDR;
            end
            default: begin
               if (valid_out && ready_out && fifo_count == '0 &&
                   !s0_valid && !s1_valid && !s2_valid) begin
                  frame_done <= 1'b1;
                  state      <= HDR;
               end
            end
         endcase
      end
   end

   // Line buffers hold the two previous rows per column; the window
   // shifts left and takes the new column {row r-2, row r-1, row r}.
   // Stale contents from earlier frames are overwritten before use.
   always_ff @(posedge clk) begin
      if (state == PIX && accept) begin
         lb0[lb_addr] <= lb1[lb_addr];
         lb1[lb_addr] <= data_in;
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
         end
         win[0][2] <= lb0[lb_addr];
         win[1][2] <= lb1[lb_addr];
         win[2][2] <= data_in;
      end
   end

   // Gradients are formed as positive and negative halves so the
   // absolute value is a plain unsigned subtraction.
   always_comb begin
      gx_p = {4'd0, win[0][2]} + {3'd0, win[1][2], 1'b0} + {4'd0, win[2][2]};
      gx_n = {4'd0, win[0][0]} + {3'd0, win[1][0], 1'b0} + {4'd0, win[2][0]};
      gy_p = {4'd0, win[2][0]} + {3'd0, win[2][1], 1'b0} + {4'd0, win[2][2]};
      gy_n = {4'd0, win[0][0]} + {3'd0, win[0][1], 1'b0} + {4'd0, win[0][2]};
      abs_gx_c = (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
      abs_gy_c = (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
   end

   // Output value selection, scaling and saturation for the frame mode.
   always_comb begin
      sum = abs_gx + abs_gy;
      case (mode_q)
         2'd1:    sel = abs_gx;
         2'd2:    sel = abs_gy;
         default: sel = sum;
      endcase
      shifted = sel >> OUT_SHIFT;
      if (mode_q == 2'd3)
         value_c = (sum >= {1'b0, thr_q}) ? 8'hFF : 8'h00;
      else
         value_c = (shifted > 12'd255) ? 8'hFF : shifted[7:0];
   end

   // Two register stages after the window: gradients, then final value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         abs_gx   <= 12'd0;
         abs_gy   <= 12'd0;
         s2_data  <= 8'd0;
      end else begin
         s1_valid <= s0_valid;
         abs_gx   <= abs_gx_c;
         abs_gy   <= abs_gy_c;
         s2_valid <= s1_valid;
         s2_data  <= value_c;
      end
   end

   // FIFO storage needs no reset; pointers and count define contents.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= s2_data;
   end

   // FIFO pointers plus the registered output stage, which refills
   // from the FIFO whenever it is empty or being consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         valid_out  <= 1'b0;
         data_out   <= 8'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            data_out  <= fifo_mem[rd_ptr];
            valid_out <= 1'b1;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream
// Scoreboard bench for sobel_stream: frames are generated with random
// or patterned pixels, expected edge pixels come from a direct 3x3
// convolution over the whole image, and a monitor compares every
// output transfer against the expected queue.
module tb_sobel_stream;

   localparam int MAXW  = 64;
   localparam int DEPTH = 16;
   localparam int SHIFT = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        valid_in;
   logic        ready_in;
   logic [1:0]  mode;
   logic [10:0] threshold;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        ready_out;
   logic        frame_done;
   logic        hdr_error;

   int compared   = 0;
   int mismatched = 0;
   int doneCount  = 0;
   int expFrames  = 0;
   int recvCount  = 0;
   int stallCount = 0;
   int rdyMode    = 0;
   int gapPct     = 0;
   bit ignoreOut  = 1'b0;
   bit holdPending = 1'b0;
   logic [7:0] heldData;
   logic [7:0] expQ[$];
   int frameImg[];

   sobel_stream #(
      .MAX_WIDTH(MAXW),
      .OUT_SHIFT(SHIFT),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .valid_in(valid_in),
      .ready_in(ready_in),
      .mode(mode),
      .threshold(threshold),
      .data_out(data_out),
      .valid_out(valid_out),
      .ready_out(ready_out),
      .frame_done(frame_done),
      .hdr_error(hdr_error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic finishBench();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   endtask

   // Reference: straight 3x3 convolution centred on (r,c).
   function automatic int sobelRef(int w, int r, int c, int md, int thr);
      int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
      int ky[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
      int gx = 0, gy = 0, ax, ay, sel, v, p;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            p = frameImg[(r + dr) * w + (c + dc)];
            gx += kx[dr + 1][dc + 1] * p;
            gy += ky[dr + 1][dc + 1] * p;
         end
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      if (md == 3) return (ax + ay >= thr) ? 255 : 0;
      sel = (md == 0) ? ax + ay : (md == 1) ? ax : ay;
      v = sel >> SHIFT;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic sendByte(input logic [7:0] b);
      bit taken = 1'b0;
      if ($urandom_range(0, 99) < gapPct) begin
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
      data_in  = b;
      valid_in = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (ready_in) begin
            taken = 1'b1;
            break;
         end
         stallCount++;
      end
      if (!taken) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL sendByte timeout: ready_in stayed 0, expected 1");
         finishBench();
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   // Builds a frame, queues its expected outputs, then streams it in.
   // kind: 0 constant 100, 1 vertical edge, 2 ramp 8r+c, else random.
   task automatic applyStimulus(input int w, input int h, input int md,
                                input int thr, input int kind, input int npix);
      bit hdrOk = (w >= 3) && (h >= 3) && (w <= MAXW);
      frameImg = new[w * h];
      for (int i = 0; i < w * h; i++) begin
         case (kind)
            0:       frameImg[i] = 100;
            1:       frameImg[i] = ((i % w) >= 2) ? 255 : 0;
            2:       frameImg[i] = (8 * (i / w) + (i % w)) & 255;
            default: frameImg[i] = $urandom_range(0, 255);
         endcase
      end
      if (hdrOk && npix == w * h) begin
         for (int r = 1; r <= h - 2; r++)
            for (int c = 1; c <= w - 2; c++)
               expQ.push_back(8'(sobelRef(w, r, c, md, thr)));
         expFrames++;
      end
      mode      = 2'(md);
      threshold = 11'(thr);
      sendByte(8'(w));
      sendByte(8'(w >> 8));
      sendByte(8'(h));
      sendByte(8'(h >> 8));
      checkOutput("hdr_error after header", int'(hdr_error), hdrOk ? 0 : 1);
      mode      = 2'($urandom);
      threshold = 11'($urandom);
      for (int i = 0; i < npix; i++)
         sendByte(8'(frameImg[i]));
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 20000; i++) begin
         if (expQ.size() == 0 && doneCount == expFrames) break;
         @(negedge clk);
      end
      checkOutput("frame_done count", doneCount, expFrames);
      checkOutput("pending outputs", expQ.size(), 0);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Downstream ready pattern: always, random, or one pulse in ten.
   initial begin
      int cnt = 0;
      ready_out = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdyMode)
            0:       ready_out = 1'b1;
            1:       ready_out = 1'($urandom_range(0, 1));
            default: begin
               ready_out = (cnt == 0);
               cnt = (cnt + 1) % 10;
            end
         endcase
      end
   end

   // Monitor: scores each output transfer and checks held data stability.
   always @(negedge clk) begin
      if (rst) begin
         holdPending = 1'b0;
      end else begin
         if (frame_done) doneCount++;
         if (holdPending) begin
            checkOutput("valid_out held", int'(valid_out), 1);
            checkOutput("data_out held", int'(data_out), int'(heldData));
         end
         if (valid_out && ready_out && !ignoreOut) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected output", 1, 0);
            end else begin
               checkOutput("edge pixel", int'(data_out), int'(expQ.pop_front()));
               recvCount++;
            end
         end
         holdPending = valid_out && !ready_out;
         heldData    = data_out;
      end
   end

   task automatic checkResetValues();
      checkOutput("reset ready_in", int'(ready_in), 1);
      checkOutput("reset valid_out", int'(valid_out), 0);
      checkOutput("reset data_out", int'(data_out), 0);
      checkOutput("reset frame_done", int'(frame_done), 0);
      checkOutput("reset hdr_error", int'(hdr_error), 0);
   endtask

   initial begin
      int base;
      rst       = 1'b1;
      data_in   = 8'd0;
      valid_in  = 1'b0;
      mode      = 2'd0;
      threshold = 11'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues();
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] constant and vertical-edge frames");
      applyStimulus(4, 4, 0, 0, 0, 16);
      waitDrain();
      checkOutput("hdr_error clean", int'(hdr_error), 0);
      applyStimulus(4, 4, 0, 0, 1, 16);
      waitDrain();
      applyStimulus(4, 4, 2, 0, 1, 16);
      waitDrain();
      applyStimulus(4, 4, 3, 1021, 1, 16);
      waitDrain();

      $display("[TB] ramp with pulsed downstream");
      rdyMode = 2;
      stallCount = 0;
      applyStimulus(8, 8, 0, 0, 2, 64);
      applyStimulus(8, 8, 1, 0, 2, 64);
      waitDrain();
      checkOutput("backpressure seen", int'(stallCount > 0), 1);
      rdyMode = 0;

      $display("[TB] bad header W=2");
      applyStimulus(2, 4, 0, 0, 0, 8);
      waitDrain();
      checkOutput("hdr_error sticky", int'(hdr_error), 1);
      applyStimulus(4, 4, 0, 0, 0, 16);
      waitDrain();
      checkOutput("hdr_error cleared", int'(hdr_error), 0);

      $display("[TB] latency on 3x3 frame");
      applyStimulus(3, 3, 0, 0, 3, 9);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("valid_out before latency", int'(valid_out), 0);
      end
      @(negedge clk);
      checkOutput("valid_out at 4th edge", int'(valid_out), 1);
      @(negedge clk);
      checkOutput("frame_done pulse", int'(frame_done), 1);
      waitDrain();

      $display("[TB] reset mid-frame");
      ignoreOut = 1'b1;
      applyStimulus(8, 8, 0, 0, 2, 48);
      rst = 1'b1;
      @(negedge clk);
      checkResetValues();
      expQ.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      ignoreOut = 1'b0;
      recvCount = 0;
      base = doneCount;
      gapPct = 20;
      applyStimulus(16, 16, $urandom_range(0, 3), $urandom_range(0, 2047), 3, 256);
      waitDrain();
      checkOutput("outputs after reset", recvCount, 196);
      checkOutput("frames after reset", doneCount - base, 1);

      $display("[TB] oversize header");
      applyStimulus(MAXW + 1, 3, 0, 0, 3, (MAXW + 1) * 3);
      waitDrain();
      checkOutput("hdr_error oversize", int'(hdr_error), 1);
      applyStimulus(5, 6, 0, 0, 3, 30);
      waitDrain();

      $display("[TB] random frames");
      rdyMode = 1;
      applyStimulus(MAXW, 3, 0, 0, 3, MAXW * 3);
      waitDrain();
      for (int f = 0; f < 6; f++) begin
         int w = $urandom_range(3, 20);
         int h = $urandom_range(3, 12);
         applyStimulus(w, h, $urandom_range(0, 3), $urandom_range(0, 2047), 3, w * h);
         waitDrain();
      end

      finishBench();
   end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming Sobel edge detector, successor to the fixed 8-bit Sobel applier. It sits between the UART receiver and the UART transmitter. Each frame arrives as a 4-byte header followed by W×H row-major 8-bit pixels, and the block emits (W−2)×(H−2) 8-bit edge pixels. Over the previous generation it adds configurable maximum line width, selectable output mode (magnitude, |Gx|, |Gy|, binary threshold), scaling, an output FIFO, and error recovery for bad headers.

## Interface
- MAX_WIDTH, 1024: largest accepted W; sets line-buffer depth (2 rows × MAX_WIDTH × 8 bits).
- OUT_SHIFT, 0: right shift applied to magnitude before saturation (0..3).
- FIFO_DEPTH, 16: output FIFO entries (power of two, ≥8).

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  8  header/pixel byte.
- valid_in  in  1  data_in valid.
- ready_in  out  1  block accepts data_in this cycle.
- mode  in  2  0 = |Gx|+|Gy|, 1 = |Gx|, 2 = |Gy|, 3 = threshold.
- threshold  in  11  mode-3 compare value.
- data_out  out  8  edge pixel.
- valid_out  out  1  data_out valid.
- ready_out  in  1  downstream consumes data_out (may be a 1-cycle pulse).
- frame_done  out  1  1-cycle pulse after the last output of a frame is consumed.
- hdr_error  out  1  sticky until next valid header: W or H < 3, or W > MAX_WIDTH.

## Operation
- Transfer in: valid_in && ready_in on a rising edge. Transfer out: valid_out && ready_out.
- States: HDR (byte counter 0..3), PIX, SKIP, DRAIN.
- HDR: bytes in order W[7:0], W[15:8], H[7:0], H[15:8]. mode and threshold are sampled on the 4th header byte and held for the frame.
  - Valid header → PIX.
  - Invalid header → SKIP, with hdr_error=1.
- PIX: row/column counters. Each pixel is written to the line buffers and a 3×3 window shifts.
  - For an accepted pixel at (r,c) with r≥2, c≥2, compute the result centred at (r−1,c−1).
  - Gx = (p[0][2]+2p[1][2]+p[2][2]) − (p[0][0]+2p[1][0]+p[2][0]). Gy is the same form, bottom row minus top row. Both are 11-bit signed, range ±1020.
  - Modes 0–2: value = min(sel>>OUT_SHIFT, 255), where sel = |Gx|+|Gy| (12-bit, ≤2040), |Gx|, or |Gy|.
  - Mode 3: 255 if |Gx|+|Gy| ≥ threshold, else 0.
  - After the last pixel (r=H−1, c=W−1) → DRAIN.
- SKIP: accept and discard W×H bytes (W and H as received, no output), then → HDR. hdr_error stays 1 until the next valid header.
- DRAIN: wait for the pipeline and FIFO to empty. Pulse frame_done on the cycle after the final output transfer, then → HDR.
- ready_in:
  - 1 in HDR and SKIP.
  - 1 in PIX only when FIFO free entries ≥ 4 (pipeline depth + 1), so no result is ever dropped.
  - 0 in DRAIN.
- Reset (any time, including mid-frame): all state returns to HDR with the byte counter at 0. FIFO is emptied and the pipeline flushed. Partial frames are discarded. Line-buffer RAM contents are not cleared.

## Timing
- Reset values: ready_in=1, valid_out=0, data_out=0, frame_done=0, hdr_error=0.
- Latency: result is written to the FIFO 3 clocks after the accepting edge. With the FIFO empty, valid_out rises on the 4th edge after acceptance.
- valid_out and data_out are registered and held stable until ready_out is sampled high. The next entry appears on the following cycle.
- Simultaneous FIFO write and read with the FIFO full: allowed; count is unchanged.
- Last header byte and first pixel may arrive on consecutive cycles with no bubble.
- W=3 or H=3 is valid and yields a single column or row of outputs.

## Test plan
- 4×4 frame, all pixels 100, mode 0 → 4 outputs, all 0; one frame_done pulse; hdr_error=0.
- 4×4 frame with columns 0–1 = 0 and columns 2–3 = 255. Mode 0 → 4 outputs of 255 (saturated 1020). Mode 2 → 4 outputs of 0. Mode 3 with threshold=1021 → 4 outputs of 0.
- 8×8 ramp (pixel = 8r+c), ready_out pulsed 1 cycle in every 10. Mode 0 → 36 outputs of 72; mode 1 → 36 outputs of 8. ready_in deasserts while the FIFO is nearly full; no loss or duplication.
- Header W=2, H=4 → hdr_error=1; 8 bytes consumed, no output. A following 4×4 constant frame then gives 4 zeros and clears hdr_error.
- Reset after 48 of 64 pixels of an 8×8 frame → outputs return to reset values on the next edge. A following 16×16 header plus 256 pixels gives exactly 196 outputs and one frame_done.
- Header W=MAX_WIDTH+1 → hdr_error=1 and SKIP; the frame is fully consumed; the next valid frame is processed normally.
